// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_pkg : shared types and constants for the 5-stage CPU control   rev 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int REG_W = 4;
    localparam logic [REG_W-1:0] ZERO_REG = 4'b0000;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } hz_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/hazard_lu_detect.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_lu_detect : combinational load-use dependency compare       rev 1.0
// ----------------------------------------------------------------------------
module hazard_lu_detect
    import cpu_pkg::*;
(
    input  logic             idex_memrd_i,
    input  logic [REG_W-1:0] idex_rd_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    output logic             lu_o
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = (idex_rd_i == ifid_rs_i);
    assign w_rt_hit = ifid_uses_rt_i && (idex_rd_i == ifid_rt_i);
    // r0 is hardwired, so a load targeting it never creates a dependency
    assign lu_o     = idex_memrd_i && (idex_rd_i != ZERO_REG) && (w_rs_hit || w_rt_hit);

endmodule : hazard_lu_detect
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_ctrl : pipeline stall / flush / halt sequencer               rev 1.0
// ----------------------------------------------------------------------------
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             ifid_hlt,
    input  logic             idex_memrd,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             br_taken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_we,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int              WAIT_W    = 8;
    localparam logic [WAIT_W-1:0] C_TIMEOUT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] C_DRAIN   = WAIT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0]  C_CNT_MAX = {CNT_W{1'b1}};

    hz_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [WAIT_W-1:0] drain_q, drain_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic              w_lu;
    logic              w_mem_stall;
    logic [WAIT_W-1:0] w_wait_inc;
    logic              run_eval;
    logic              pc_we_c, ifid_we_c, ifid_flush_c, idex_flush_c, pipe_we_c;

    hazard_lu_detect u_lu (
        .idex_memrd_i   (idex_memrd),
        .idex_rd_i      (idex_rd),
        .ifid_rs_i      (ifid_rs),
        .ifid_rt_i      (ifid_rt),
        .ifid_uses_rt_i (ifid_uses_rt),
        .lu_o           (w_lu)
    );

    assign w_mem_stall = dmem_req && !dmem_ready;
    assign w_wait_inc  = wait_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        drain_d      = drain_q;
        err_d        = err_q;
        run_eval     = 1'b0;
        pc_we_c      = 1'b0;
        ifid_we_c    = 1'b0;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        pipe_we_c    = 1'b0;

        case (state_q)
            RUN: begin
                if (w_mem_stall) begin
                    state_d = MEMWAIT;
                    wait_d  = 8'd1;
                end else begin
                    wait_d   = '0;
                    run_eval = 1'b1;
                end
            end
            MEMWAIT: begin
                // the completing cycle behaves like RUN so pending hazards act immediately
                if (dmem_ready) begin
                    state_d  = RUN;
                    wait_d   = '0;
                    run_eval = 1'b1;
                end else begin
                    wait_d = w_wait_inc;
                    if (w_wait_inc == C_TIMEOUT) begin
                        err_d   = 1'b1;
                        state_d = HALTED;
                    end
                end
            end
            DRAIN: begin
                ifid_we_c    = 1'b1;
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
                pipe_we_c    = 1'b1;
                if (w_mem_stall) begin
                    pipe_we_c = 1'b0;
                    wait_d    = w_wait_inc;
                    if (w_wait_inc == C_TIMEOUT) begin
                        err_d   = 1'b1;
                        state_d = HALTED;
                    end
                end else begin
                    wait_d = '0;
                    if (drain_q <= 8'd1) begin
                        state_d = HALTED;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (run_eval) begin
            if (br_taken_ex) begin
                pc_we_c      = 1'b1;
                ifid_we_c    = 1'b1;
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
                pipe_we_c    = 1'b1;
            end else if (w_lu) begin
                idex_flush_c = 1'b1;
                pipe_we_c    = 1'b1;
            end else if (ifid_hlt) begin
                ifid_we_c    = 1'b1;
                ifid_flush_c = 1'b1;
                pipe_we_c    = 1'b1;
                state_d      = DRAIN;
                drain_d      = C_DRAIN;
            end else begin
                pc_we_c   = 1'b1;
                ifid_we_c = 1'b1;
                pipe_we_c = 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_we_c && (state_q != HALTED) && (stall_q != C_CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    // controls are forced to their safe values for as long as reset is held
    assign pc_we      = rst_n & pc_we_c;
    assign ifid_we    = rst_n & ifid_we_c;
    assign ifid_flush = !rst_n | ifid_flush_c;
    assign idex_flush = !rst_n | idex_flush_c;
    assign pipe_we    = rst_n & pipe_we_c;
    assign halted     = (state_q == HALTED);
    assign mem_err    = err_q;
    assign stall_cnt  = stall_q;

endmodule : hazard_ctrl
`default_nettype wire
